// File: rtl/line_cmd_sequencer.sv
// line_cmd_sequencer
//   Queues line commands (x0,y0,x1,y1) in a small FIFO and feeds them one at
//   a time to the line drawer: latch the coordinates, pulse the drawer reset,
//   hold start until the drawer reports finish (or the watchdog expires), then
//   count the line and move on.
//   Optional feature macro: LINE_CLIP_EN clamps coordinates to the visible
//   screen (SCREEN_W x SCREEN_H) when they are loaded.
module line_cmd_sequencer #(
  parameter int WIDTH    = 13,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 600000,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_x0,
  input  logic [WIDTH-1:0]           cmd_y0,
  input  logic [WIDTH-1:0]           cmd_x1,
  input  logic [WIDTH-1:0]           cmd_y1,
  output logic                       draw_reset,
  output logic                       draw_start,
  output logic [WIDTH-1:0]           draw_x0,
  output logic [WIDTH-1:0]           draw_y0,
  output logic [WIDTH-1:0]           draw_x1,
  output logic [WIDTH-1:0]           draw_y1,
  input  logic                       draw_finish,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                lines_done,
  output logic                       timeout_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] X_MAX   = WIDTH'(SCREEN_W - 1);
  localparam logic [WIDTH-1:0] Y_MAX   = WIDTH'(SCREEN_H - 1);

`ifdef LINE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    START,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [4*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               push;
  logic               pop;

  logic [WDW-1:0]     wd;
  logic               wd_expire;
  logic               set_timeout;

  logic [4*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_x0, head_y0, head_x1, head_y1;
  logic [WIDTH-1:0]   ld_x0, ld_y0, ld_x1, ld_y1;

  assign cmd_ready  = (count != CW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);
  assign wd_expire  = (TIMEOUT != 0) && (wd == WD_LAST);

  assign head = mem[rd_ptr];
  assign {head_x0, head_y0, head_x1, head_y1} = head;

  // Coordinates as they will be registered at LOAD, clamped when clipping is built in
  assign ld_x0 = (CLIP_EN && (head_x0 > X_MAX)) ? X_MAX : head_x0;
  assign ld_y0 = (CLIP_EN && (head_y0 > Y_MAX)) ? Y_MAX : head_y0;
  assign ld_x1 = (CLIP_EN && (head_x1 > X_MAX)) ? X_MAX : head_x1;
  assign ld_y1 = (CLIP_EN && (head_y1 > Y_MAX)) ? Y_MAX : head_y1;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // Dispatch state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and drawer handshake; finish is only looked at while waiting
  always_comb begin
    next_state  = state;
    draw_reset  = 1'b0;
    draw_start  = 1'b0;
    pop         = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        pop        = 1'b1;
        next_state = CLR;
      end
      CLR: begin
        draw_reset = 1'b1;
        next_state = START;
      end
      START: begin
        draw_start = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        draw_start = 1'b1;
        if (draw_finish) begin
          next_state = DONE;
        end else if (wd_expire) begin
          set_timeout = 1'b1;
          next_state  = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latched drawer coordinates, held until the next LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_x0 <= '0;
      draw_y0 <= '0;
      draw_x1 <= '0;
      draw_y1 <= '0;
    end else if (state == LOAD) begin
      draw_x0 <= ld_x0;
      draw_y0 <= ld_y0;
      draw_x1 <= ld_x1;
      draw_y1 <= ld_y1;
    end
  end

  // Watchdog: restarts at START, counts every cycle spent waiting for finish
  always_ff @(posedge clk) begin
    if (reset) begin
      wd <= '0;
    end else if (state == START) begin
      wd <= '0;
    end else if (state == WAIT) begin
      wd <= wd + 1'b1;
    end
  end

  // Completed-line counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      lines_done  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == DONE) begin
        lines_done <= lines_done + 16'd1;
      end
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// tb_line_cmd_sequencer
//   Directed bench for line_cmd_sequencer with a simple drawer model whose
//   finish flag is sticky until the drawer reset pulse, like the real drawer.
module tb_line_cmd_sequencer;

  localparam int WIDTH = 13;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic             draw_reset, draw_start;
  logic [WIDTH-1:0] draw_x0, draw_y0, draw_x1, draw_y1;
  logic             draw_finish;
  logic             busy;
  logic [3:0]       fifo_count;
  logic [15:0]      lines_done;
  logic             timeout_err;

  int total = 0;
  int bad   = 0;

  // Drawer model controls and state
  int   fin_delay = 50;
  bit   stall = 1'b0;
  logic fin = 1'b0;
  int   fin_cnt = 0;

  // Monitor bookkeeping
  int              reset_cyc = 0;
  int              start_cyc = 0;
  logic [4*WIDTH-1:0] drawn [$];

  assign draw_finish = fin;

  line_cmd_sequencer #(
    .WIDTH(WIDTH), .DEPTH(8), .TIMEOUT(100), .SCREEN_W(640), .SCREEN_H(480)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .draw_reset(draw_reset), .draw_start(draw_start),
    .draw_x0(draw_x0), .draw_y0(draw_y0), .draw_x1(draw_x1), .draw_y1(draw_y1),
    .draw_finish(draw_finish), .busy(busy), .fifo_count(fifo_count),
    .lines_done(lines_done), .timeout_err(timeout_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Drawer model: raises finish after fin_delay start cycles, holds it until reset
  always @(posedge clk) begin
    if (reset || draw_reset) begin
      fin     <= 1'b0;
      fin_cnt <= 0;
    end else if (draw_start && !fin && !stall) begin
      if (fin_cnt == fin_delay - 1) fin <= 1'b1;
      fin_cnt <= fin_cnt + 1;
    end
  end

  // Monitor: records coordinates at each reset pulse and counts pulse/start cycles
  always @(negedge clk) begin
    if (draw_reset) drawn.push_back({draw_x0, draw_y0, draw_x1, draw_y1});
    if (draw_reset) reset_cyc = reset_cyc + 1;
    if (draw_start) start_cyc = start_cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one command and hold it until it is accepted; returns at the negedge after the push
  task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1);
    int n;
    cmd_x0 = WIDTH'(x0);
    cmd_y0 = WIDTH'(y0);
    cmd_x1 = WIDTH'(x1);
    cmd_y1 = WIDTH'(y1);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("push_accept", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(busy), 0);
  endtask

  initial begin
    int s_rst, s_start, base;
    logic [4*WIDTH-1:0] exp_word;
    $display("[TB] starting");

    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ready", 32'(cmd_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_count", 32'(fifo_count), 0);
    checkOutput("rst_dreset", 32'(draw_reset), 0);
    checkOutput("rst_dstart", 32'(draw_start), 0);
    checkOutput("rst_lines", 32'(lines_done), 0);
    checkOutput("rst_tmo", 32'(timeout_err), 0);
    checkOutput("rst_x0", 32'(draw_x0), 0);

    // Single line with a 50-cycle drawer
    #1;
    s_rst = reset_cyc;
    s_start = start_cyc;
    fin_delay = 50;
    stall = 1'b0;
    applyStimulus(10, 20, 100, 20);
    checkOutput("t1_count", 32'(fifo_count), 1);
    checkOutput("t1_no_bypass", 32'(draw_reset), 0);
    @(negedge clk);
    checkOutput("t1_load_noreset", 32'(draw_reset), 0);
    @(negedge clk);
    checkOutput("t1_reset_lat", 32'(draw_reset), 1);
    checkOutput("t1_nostart", 32'(draw_start), 0);
    @(negedge clk);
    checkOutput("t1_start_lat", 32'(draw_start), 1);
    checkOutput("t1_reset_drop", 32'(draw_reset), 0);
    waitIdle("t1_idle", 300);
    #1;
    checkOutput("t1_rst_width", 32'(reset_cyc - s_rst), 1);
    checkOutput("t1_start_len", 32'(start_cyc - s_start), 51);
    checkOutput("t1_lines", 32'(lines_done), 1);
    checkOutput("t1_x0", 32'(draw_x0), 10);
    checkOutput("t1_y0", 32'(draw_y0), 20);
    checkOutput("t1_x1", 32'(draw_x1), 100);
    checkOutput("t1_y1", 32'(draw_y1), 20);

    // Stale finish from the previous line must not count or shorten the next line
    repeat (5) @(negedge clk);
    checkOutput("t3_idle_lines", 32'(lines_done), 1);
    checkOutput("t3_idle_busy", 32'(busy), 0);
    #1;
    s_start = start_cyc;
    applyStimulus(1, 2, 3, 4);
    waitIdle("t3_idle", 300);
    #1;
    checkOutput("t3_start_len", 32'(start_cyc - s_start), 51);
    checkOutput("t3_lines", 32'(lines_done), 2);

    // Nine back-to-back commands against a stalled drawer
    stall = 1'b1;
    fin_delay = 5;
    #1;
    base = drawn.size();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(i * 3, i * 5 + 1, 600 - i, 400 + i);
    end
    checkOutput("t2_full_count", 32'(fifo_count), 8);
    checkOutput("t2_full_ready", 32'(cmd_ready), 0);
    checkOutput("t2_busy", 32'(busy), 1);
    stall = 1'b0;
    waitIdle("t2_idle", 2000);
    #1;
    checkOutput("t2_ndrawn", 32'(drawn.size() - base), 9);
    for (int i = 0; i < 9; i++) begin
      exp_word = {WIDTH'(i * 3), WIDTH'(i * 5 + 1), WIDTH'(600 - i), WIDTH'(400 + i)};
      if (base + i < drawn.size())
        checkOutput($sformatf("t2_order%0d_x0", i), 32'(drawn[base + i][4*WIDTH-1:3*WIDTH]), 32'(exp_word[4*WIDTH-1:3*WIDTH]));
      if (base + i < drawn.size())
        checkOutput($sformatf("t2_order%0d_y1", i), 32'(drawn[base + i][WIDTH-1:0]), 32'(exp_word[WIDTH-1:0]));
    end
    checkOutput("t2_lines", 32'(lines_done), 11);
    checkOutput("t2_tmo", 32'(timeout_err), 0);

    // Drawer never finishes: watchdog ends the line after 100 waiting cycles
    stall = 1'b1;
    #1;
    s_start = start_cyc;
    applyStimulus(7, 8, 9, 10);
    waitIdle("t4_idle", 500);
    #1;
    checkOutput("t4_start_len", 32'(start_cyc - s_start), 101);
    checkOutput("t4_tmo", 32'(timeout_err), 1);
    checkOutput("t4_lines", 32'(lines_done), 12);
    stall = 1'b0;
    applyStimulus(11, 12, 13, 14);
    waitIdle("t4_next_idle", 300);
    checkOutput("t4_next_lines", 32'(lines_done), 13);
    checkOutput("t4_next_x0", 32'(draw_x0), 11);
    checkOutput("t4_tmo_sticky", 32'(timeout_err), 1);

    // Reset while waiting with three lines queued
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(50 + i, 60 + i, 70 + i, 80 + i);
    end
    checkOutput("t5_queued", 32'(fifo_count), 3);
    checkOutput("t5_started", 32'(draw_start), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_count", 32'(fifo_count), 0);
    checkOutput("t5_start", 32'(draw_start), 0);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_ready", 32'(cmd_ready), 1);
    checkOutput("t5_lines", 32'(lines_done), 0);
    checkOutput("t5_tmo", 32'(timeout_err), 0);
    checkOutput("t5_x0", 32'(draw_x0), 0);
    reset = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_stay_idle", 32'(busy), 0);

    // Out-of-screen coordinates: clamped only when clipping is built in
    applyStimulus(700, 500, 5, 479);
    waitIdle("t6_idle", 300);
`ifdef LINE_CLIP_EN
    checkOutput("t6_x0", 32'(draw_x0), 639);
    checkOutput("t6_y0", 32'(draw_y0), 479);
`else
    checkOutput("t6_x0", 32'(draw_x0), 700);
    checkOutput("t6_y0", 32'(draw_y0), 500);
`endif
    checkOutput("t6_x1", 32'(draw_x1), 5);
    checkOutput("t6_y1", 32'(draw_y1), 479);
    checkOutput("t6_lines", 32'(lines_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
